// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-CHANNELS stream demultiplexer with valid/ready
// handshakes, broadcast mode, drop-and-flag of out-of-range selects and a
// saturating drop counter.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   producer has a word
//   in_ready   out  word is accepted this cycle (combinational from out_ready)
//   in_data    in   payload [WIDTH]
//   in_sel     in   destination channel index [SELW]
//   in_bcast   in   1 = deliver to every channel, in_sel ignored
//   out_valid  out  per-channel valid [CHANNELS]
//   out_ready  in   per-channel ready [CHANNELS]
//   out_data   out  shared held payload [WIDTH]
//   err        out  one-cycle pulse after an out-of-range word is dropped
//   drop_cnt   out  saturating count of dropped words [8]
//
// State view (derived from the pending mask, no separate encoding):
//   state          | meaning
//   EMPTY          | pend == 0, ready for a new word
//   UNICAST        | exactly one channel still owes a handshake
//   BCAST_PARTIAL  | several channels still owe a handshake; mask only shrinks
module stream_demux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_data,
  input  logic [SELW-1:0]     in_sel,
  input  logic                in_bcast,
  output logic [CHANNELS-1:0] out_valid,
  input  logic [CHANNELS-1:0] out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                err,
  output logic [7:0]          drop_cnt
);

  localparam int unsigned CH_U = CHANNELS;

  logic [CHANNELS-1:0] pend_q, pend_d, pend_nx, sel_onehot;
  logic [WIDTH-1:0]    hold_q, hold_d;
  logic                err_q, err_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                sel_ok, accept;

  // Channels that would still be pending after this cycle's handshakes.
  // A new word may enter in the same cycle the last channel completes.
  assign pend_nx  = pend_q & ~out_ready;
  assign in_ready = (pend_nx == '0);
  assign accept   = in_valid & in_ready;

  // in_sel can encode more values than there are channels when CHANNELS
  // is not a power of two.
  assign sel_ok     = (32'(in_sel) < CH_U);
  assign sel_onehot = {{(CHANNELS-1){1'b0}}, 1'b1} << in_sel;

  always_comb begin
    pend_d = pend_nx;
    hold_d = hold_q;
    err_d  = 1'b0;
    cnt_d  = cnt_q;
    if (accept) begin
      if (in_bcast) begin
        pend_d = '1;
        hold_d = in_data;
      end else if (sel_ok) begin
        pend_d = sel_onehot;
        hold_d = in_data;
      end else begin
        // Word is consumed but goes nowhere; payload register keeps its value.
        pend_d = '0;
        err_d  = 1'b1;
        if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      hold_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= 8'd0;
    end else begin
      pend_q <= pend_d;
      hold_q <= hold_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid = pend_q;
  assign out_data  = hold_q;
  assign err       = err_q;
  assign drop_cnt  = cnt_q;

endmodule
